tune_sequencer: RTL and testbench

//  Parametrised piezo tune player; the successor to the single-tune charge player.
//  - Plays one of NUM_TUNES note tables on a differential piezo pair. Each note is a
//    {half-period, duration} pair and may be a rest.
//  - Triggered by a one-cycle go pulse from the push-button release detector.
//  - Reports busy/done and the current note index to the top level.

---
 rtl/tune_pkg.sv | 66 ++++++
 rtl/tune_rom.sv | 39 +++
 rtl/tune_sequencer.sv | 150 +++++++++++++++
 tb/tb_tune_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tune_pkg.sv
// ============================================================================
// Module  : tune_pkg
// Purpose : Shared note/state types, note half-periods and the tune tables
//           for the piezo tune sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package tune_pkg;

  localparam int TUNE_HP_W      = 16;
  localparam int TUNE_DUR_W     = 26;
  localparam int TUNE_NUM_TUNES = 4;
  localparam int TUNE_MAX_NOTES = 8;

  typedef struct packed {
    logic [TUNE_HP_W-1:0]  hp;
    logic [TUNE_DUR_W-1:0] dur;
  } note_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    PLAY   = 2'd2,
    FINISH = 2'd3
  } state_t;

  // Half-periods in 50 MHz clock cycles; a zero half-period is a rest
  localparam logic [TUNE_HP_W-1:0] HP_G6   = 16'd15944;
  localparam logic [TUNE_HP_W-1:0] HP_C7   = 16'd11945;
  localparam logic [TUNE_HP_W-1:0] HP_E7   = 16'd9480;
  localparam logic [TUNE_HP_W-1:0] HP_G7   = 16'd7972;
  localparam logic [TUNE_HP_W-1:0] HP_REST = 16'd0;

  function automatic note_t mk_note(input logic [TUNE_HP_W-1:0] hp,
                                    input logic [TUNE_DUR_W-1:0] dur);
    note_t n;
    n.hp  = hp;
    n.dur = dur;
    return n;
  endfunction

  // A zero duration terminates a tune. Tune 0 is the charge fanfare; tunes
  // 1..3 are short status chirps, tunes 2 and 3 fill the whole table.
  localparam note_t TUNE_TABLE [TUNE_NUM_TUNES][TUNE_MAX_NOTES] = '{
    '{mk_note(HP_G6, 26'd8388608),  mk_note(HP_C7, 26'd8388608),
      mk_note(HP_E7, 26'd8388608),  mk_note(HP_G7, 26'd12582912),
      mk_note(HP_E7, 26'd4194304),  mk_note(HP_G7, 26'd33554432),
      mk_note(HP_REST, 26'd0),      mk_note(HP_REST, 26'd0)},
    '{mk_note(HP_C7, 26'd16384),    mk_note(HP_REST, 26'd8192),
      mk_note(HP_E7, 26'd16390),    mk_note(HP_G7, 26'd16384),
      mk_note(HP_REST, 26'd0),      mk_note(HP_REST, 26'd0),
      mk_note(HP_REST, 26'd0),      mk_note(HP_REST, 26'd0)},
    '{mk_note(HP_G6, 26'd8192),     mk_note(HP_C7, 26'd8192),
      mk_note(HP_E7, 26'd8192),     mk_note(HP_G7, 26'd8192),
      mk_note(HP_E7, 26'd8192),     mk_note(HP_C7, 26'd8192),
      mk_note(HP_G6, 26'd8192),     mk_note(HP_C7, 26'd8192)},
    '{mk_note(HP_G7, 26'd8192),     mk_note(HP_E7, 26'd8192),
      mk_note(HP_C7, 26'd8192),     mk_note(HP_G6, 26'd8192),
      mk_note(HP_G7, 26'd8192),     mk_note(HP_E7, 26'd8192),
      mk_note(HP_C7, 26'd8192),     mk_note(HP_G6, 26'd8200)}
  };

endpackage

`default_nettype wire

// File: rtl/tune_rom.sv
// ============================================================================
// Module  : tune_rom
// Purpose : Combinational tune table lookup; anything outside the selectable
//           tunes or the note range reads back as a terminator.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tune_rom
  import tune_pkg::*;
#(
  parameter int NUM_TUNES = TUNE_NUM_TUNES,
  parameter int MAX_NOTES = TUNE_MAX_NOTES,
  parameter int SEL_W     = 2,
  parameter int IDX_W     = 4
) (
  input  logic [SEL_W-1:0] i_tune_sel,
  input  logic [IDX_W-1:0] i_note_idx,
  output note_t            o_note
);

  localparam int TUNE_IW = $clog2(TUNE_NUM_TUNES);
  localparam int NOTE_IW = $clog2(TUNE_MAX_NOTES);

  logic               w_in_range;
  logic [TUNE_IW-1:0] w_tune;
  logic [NOTE_IW-1:0] w_note;

  always_comb begin
    w_in_range = (int'(i_tune_sel) < NUM_TUNES) && (int'(i_tune_sel) < TUNE_NUM_TUNES) &&
                 (int'(i_note_idx) < MAX_NOTES) && (int'(i_note_idx) < TUNE_MAX_NOTES);
    w_tune     = TUNE_IW'(i_tune_sel);
    w_note     = NOTE_IW'(i_note_idx);
    o_note     = w_in_range ? TUNE_TABLE[w_tune][w_note] : '0;
  end

endmodule

`default_nettype wire

// File: rtl/tune_sequencer.sv
// ============================================================================
// Module  : tune_sequencer
// Purpose : Plays one of NUM_TUNES note tables on a differential piezo pair.
//           Optional macro TUNE_REPEAT_EN adds repeat_mode for looping tunes.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tune_sequencer
  import tune_pkg::*;
#(
  parameter  int FAST_SIM  = 0,
  parameter  int NUM_TUNES = 4,
  parameter  int MAX_NOTES = 8,
  parameter  int HP_W      = 16,
  parameter  int DUR_W     = 26,
  localparam int SEL_W     = (NUM_TUNES > 1) ? $clog2(NUM_TUNES) : 1,
  localparam int IDX_W     = $clog2(MAX_NOTES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [SEL_W-1:0] tune_sel,
`ifdef TUNE_REPEAT_EN
  input  logic             repeat_mode,
`endif
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] note_idx,
  output logic             piezo,
  output logic             piezo_n
);

  localparam logic [DUR_W:0] DUR_STEP = (FAST_SIM != 0) ? (DUR_W+1)'(16) : (DUR_W+1)'(1);

  state_t           r_state;
  state_t           w_state_next;
  logic [SEL_W-1:0] r_sel;
  logic [IDX_W-1:0] r_idx;
  logic [HP_W-1:0]  r_hp;
  logic [HP_W-1:0]  r_tone_cnt;
  logic [DUR_W-1:0] r_dur;
  logic [DUR_W-1:0] r_dur_cnt;
  logic             r_tone;
  note_t            w_rom_note;
  logic [DUR_W:0]   w_dur_sum;
  logic             w_note_end;
  logic             w_tone_wrap;
  logic             w_is_term;
  logic             w_restart;
  logic             w_sounding;

  tune_rom #(
    .NUM_TUNES (NUM_TUNES),
    .MAX_NOTES (MAX_NOTES),
    .SEL_W     (SEL_W),
    .IDX_W     (IDX_W)
  ) u_rom (
    .i_tune_sel (r_sel),
    .i_note_idx (r_idx),
    .o_note     (w_rom_note)
  );

  // Extra bit on the duration sum keeps the coarse FAST_SIM step from wrapping past dur
  assign w_dur_sum   = {1'b0, r_dur_cnt} + DUR_STEP;
  assign w_note_end  = (w_dur_sum >= {1'b0, r_dur});
  assign w_tone_wrap = (r_hp != '0) && (r_tone_cnt == r_hp - HP_W'(1));
  assign w_is_term   = (w_rom_note.dur == '0) || (r_idx == IDX_W'(MAX_NOTES));
  assign w_sounding  = (r_state == PLAY) && (r_hp != '0);
`ifdef TUNE_REPEAT_EN
  assign w_restart   = w_is_term && repeat_mode;
`else
  assign w_restart   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (go) w_state_next = LOAD;
      LOAD: begin
        if (w_restart)      w_state_next = LOAD;
        else if (w_is_term) w_state_next = FINISH;
        else                w_state_next = PLAY;
      end
      PLAY:    if (w_note_end) w_state_next = LOAD;
      FINISH:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel      <= '0;
      r_idx      <= '0;
      r_hp       <= '0;
      r_dur      <= '0;
      r_tone_cnt <= '0;
      r_dur_cnt  <= '0;
      r_tone     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      note_idx   <= '0;
      piezo      <= 1'b0;
      piezo_n    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (go) begin
            r_sel <= tune_sel;
            r_idx <= '0;
          end
        end
        LOAD: begin
          r_hp       <= HP_W'(w_rom_note.hp);
          r_dur      <= DUR_W'(w_rom_note.dur);
          r_tone_cnt <= '0;
          r_dur_cnt  <= '0;
          r_tone     <= 1'b0;
          if (w_restart) r_idx <= '0;
        end
        PLAY: begin
          if (w_tone_wrap) begin
            r_tone_cnt <= '0;
            r_tone     <= ~r_tone;
          end else if (r_hp != '0) begin
            r_tone_cnt <= r_tone_cnt + HP_W'(1);
          end
          r_dur_cnt <= DUR_W'(w_dur_sum);
          if (w_note_end) r_idx <= r_idx + IDX_W'(1);
        end
        default: ;
      endcase

      // Output stage: every port is a register, one cycle behind the FSM
      busy     <= (r_state == LOAD) || (r_state == PLAY);
      done     <= (r_state == FINISH);
      note_idx <= r_idx;
      piezo    <= w_sounding & r_tone;
      piezo_n  <= w_sounding & ~r_tone;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tune_sequencer.sv
// ============================================================================
// Module  : tb_tune_sequencer
// Purpose : Randomised self-checking bench for tune_sequencer against a
//           timeline model of note schedules (TUNE_REPEAT_EN adds a loop test).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tune_sequencer;

  localparam int NUM_TUNES = 3;
  localparam int MAX_NOTES = 8;
  localparam int SEL_W     = 2;
  localparam int IDX_W     = 4;
  localparam int STEP      = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             go = 1'b0;
  logic [SEL_W-1:0] tune_sel = '0;
`ifdef TUNE_REPEAT_EN
  logic             repeat_mode = 1'b0;
`endif
  logic             busy;
  logic             done;
  logic [IDX_W-1:0] note_idx;
  logic             piezo;
  logic             piezo_n;

  int checks   = 0;
  int failures = 0;
  int hp_tab  [4][8];
  int dur_tab [4][8];

  tune_sequencer #(
    .FAST_SIM  (1),
    .NUM_TUNES (NUM_TUNES),
    .MAX_NOTES (MAX_NOTES),
    .HP_W      (16),
    .DUR_W     (26)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .go          (go),
    .tune_sel    (tune_sel),
`ifdef TUNE_REPEAT_EN
    .repeat_mode (repeat_mode),
`endif
    .busy        (busy),
    .done        (done),
    .note_idx    (note_idx),
    .piezo       (piezo),
    .piezo_n     (piezo_n)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int n_notes(input int sel);
    if (sel >= NUM_TUNES) return 0;
    for (int i = 0; i < MAX_NOTES; i++)
      if (dur_tab[sel][i] == 0) return i;
    return MAX_NOTES;
  endfunction

  function automatic int play_cycles(input int d);
    return (d + STEP - 1) / STEP;
  endfunction

  // Cycle (counted from the go edge) at which the terminating LOAD is visible
  function automatic int end_cycle(input int sel);
    int s;
    s = 1;
    for (int i = 0; i < n_notes(sel); i++) s += 1 + play_cycles(dur_tab[sel][i]);
    return s;
  endfunction

  // Expected {busy, done, note_idx, piezo, piezo_n} k cycles after the go edge
  function automatic logic [7:0] expect_at(input int sel, input int k);
    int s;
    int n;
    s = 1;
    n = n_notes(sel);
    for (int i = 0; i < n; i++) begin
      int len;
      int h;
      bit ph;
      len = play_cycles(dur_tab[sel][i]);
      h   = hp_tab[sel][i];
      if (k == s) return {2'b10, 4'(i), 2'b00};
      if (k > s && k <= s + len) begin
        if (h == 0) return {2'b10, 4'(i), 2'b00};
        ph = (((k - s - 1) / h) % 2) != 0;
        return {2'b10, 4'(i), ph, ~ph};
      end
      s += 1 + len;
    end
    if (k == s)     return {2'b10, 4'(n), 2'b00};
    if (k == s + 1) return {2'b01, 4'(n), 2'b00};
    return {2'b00, 4'(n), 2'b00};
  endfunction

  task automatic reset_abort();
    rst = 1'b1;
    #1;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_idx", note_idx, 0);
    check_eq("abort_piezo", {piezo, piezo_n}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check_eq("abort_quiet", {busy, done, piezo, piezo_n}, 0);
    end
  endtask

  task automatic run_tune(input int sel, input bit spam, input int abort_k);
    int          k_end;
    int          dones;
    int          rise_k;
    int          fall_k;
    logic [7:0]  obs;
    k_end  = end_cycle(sel);
    dones  = 0;
    rise_k = -1;
    fall_k = -1;
    @(negedge clk);
    tune_sel = SEL_W'(sel);
    go       = 1'b1;
    @(negedge clk);
    go = 1'b0;
    for (int k = 0; k <= k_end + 2; k++) begin
      if (k >= 1) begin
        obs = {busy, done, note_idx, piezo, piezo_n};
        check_eq($sformatf("trace sel%0d k%0d", sel, k), obs, expect_at(sel, k));
        if (piezo && rise_k < 0) rise_k = k;
        if (!piezo && rise_k >= 0 && fall_k < 0) fall_k = k;
        dones += int'(done);
      end
      if (k == abort_k) begin
        if (sel == 0) begin
          check_eq("first_edge", rise_k, 2 + 15944);
          check_eq("tone_period", 2 * (fall_k - rise_k), 31888);
        end
        reset_abort();
        return;
      end
      if (spam && k < k_end - 1) begin
        go       = 1'($urandom_range(0, 1));
        tune_sel = SEL_W'($urandom);
      end else begin
        go = 1'b0;
      end
      @(negedge clk);
    end
    check_eq($sformatf("done_count sel%0d", sel), dones, 1);
  endtask

  initial begin
    hp_tab[0]  = '{15944, 11945, 9480, 7972, 9480, 7972, 0, 0};
    dur_tab[0] = '{8388608, 8388608, 8388608, 12582912, 4194304, 33554432, 0, 0};
    hp_tab[1]  = '{11945, 0, 9480, 7972, 0, 0, 0, 0};
    dur_tab[1] = '{16384, 8192, 16390, 16384, 0, 0, 0, 0};
    hp_tab[2]  = '{15944, 11945, 9480, 7972, 9480, 11945, 15944, 11945};
    dur_tab[2] = '{8192, 8192, 8192, 8192, 8192, 8192, 8192, 8192};
    hp_tab[3]  = '{7972, 9480, 11945, 15944, 7972, 9480, 11945, 15944};
    dur_tab[3] = '{8192, 8192, 8192, 8192, 8192, 8192, 8192, 8200};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_idx", note_idx, 0);
    check_eq("rst_piezo", piezo, 0);
    check_eq("rst_piezo_n", piezo_n, 0);
    rst = 1'b0;
    @(negedge clk);

    // Charge fanfare: latency and tone period on note 0, then abort by reset
    run_tune(0, 1'b0, 2 + 2 * 15944 + 20);
    // Abort somewhere inside note 2 of the full-length tune
    run_tune(2, 1'b0, 1 + 2 * 513 + 1 + $urandom_range(0, 511));
    run_tune(1, 1'b0, -1);
    run_tune(3, 1'b0, -1);
    run_tune(2, 1'b0, -1);
    run_tune(1, 1'b1, -1);

    for (int r = 0; r < 5; r++) begin
      int sel;
      int ab;
      sel = $urandom_range(1, 3);
      ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, end_cycle(sel)) : -1;
      repeat ($urandom_range(0, 7)) @(negedge clk);
      run_tune(sel, 1'($urandom_range(0, 1)), ab);
    end

`ifdef TUNE_REPEAT_EN
    begin
      int pass_len;
      int dones;
      int wraps;
      int not_busy;
      int waited;
      logic [IDX_W-1:0] prev_idx;
      pass_len    = end_cycle(1);
      dones       = 0;
      wraps       = 0;
      not_busy    = 0;
      repeat_mode = 1'b1;
      @(negedge clk);
      tune_sel = SEL_W'(1);
      go       = 1'b1;
      @(negedge clk);
      go       = 1'b0;
      prev_idx = note_idx;
      for (int k = 1; k <= 2 * pass_len + 5; k++) begin
        @(negedge clk);
        dones    += int'(done);
        not_busy += int'(!busy);
        if (prev_idx != 0 && note_idx == 0) wraps++;
        prev_idx = note_idx;
      end
      check_eq("repeat_no_done", dones, 0);
      check_eq("repeat_busy_held", not_busy, 0);
      check_eq("repeat_wrapped", wraps >= 1, 1);
      repeat_mode = 1'b0;
      waited = 0;
      while (!done && waited < 2 * pass_len + 10) begin
        @(negedge clk);
        waited++;
      end
      check_eq("repeat_final_done", done, 1);
      check_eq("repeat_busy_falls", busy, 0);
      @(negedge clk);
      check_eq("repeat_done_pulse", done, 0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
